// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with a bounded grant tenure.
// Each tenure ends after one bubble cycle; MAX_HOLD expiry pulses timeout.
module rr_arbiter_8 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] MAX_H = 4'(MAX_HOLD);

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;
    logic [7:0] gnt_q, gnt_d;
    logic       timeout_q, timeout_d;

    logic [2:0] win_idx;
    logic       win_found;
    logic [2:0] cand;

    // Rotating search: first asserted request at ptr, ptr+1, ... mod 8.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int i = 0; i < 8; i++) begin
            cand = ptr_q + 3'(i);
            if (!win_found && req[cand]) begin
                win_idx   = cand;
                win_found = 1'b1;
            end
        end
    end

    // Tenure control: grant on any request, end on drop or hold expiry.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d    = GRANT;
                    idx_d      = win_idx;
                    hold_cnt_d = 4'd1;
                end
            end
            GRANT: begin
                if (!req[idx_q]) begin
                    state_d    = IDLE;
                    ptr_d      = idx_q + 3'd1;
                    idx_d      = '0;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q >= MAX_H) begin
                    state_d    = IDLE;
                    ptr_d      = idx_q + 3'd1;
                    idx_d      = '0;
                    hold_cnt_d = '0;
                    timeout_d  = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end
            end
        endcase
        gnt_d = (state_d == GRANT) ? (8'd1 << idx_d) : 8'd0;
    end

    // State and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            idx_q      <= '0;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = (state_q == GRANT);
    assign timeout   = timeout_q;

endmodule
